// File: rtl/frame_render_ctrl_if.sv
// Renderer / framebuffer bus for frame_render_ctrl.
// The master side is the controller: it presents x/y to the renderer,
// receives pix_data and issues framebuffer writes. The slave side is the
// surrounding system (renderer, framebuffer, vblank source).
interface frame_render_ctrl_if;
  logic        frame_start;
  logic [7:0]  pix_data;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        snap_en;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  modport master (
    input  frame_start, pix_data,
    output x, y, snap_en, wr_en, wr_addr, wr_data, busy, frame_done, drop_cnt
  );

  modport slave (
    output frame_start, pix_data,
    input  x, y, snap_en, wr_en, wr_addr, wr_data, busy, frame_done, drop_cnt
  );
endinterface

// File: rtl/frame_render_ctrl.sv
// Frame render controller: on a vblank request it snapshots game state,
// scans every framebuffer pixel in row-major order and writes the colour
// returned by the renderer one cycle later. One request can be queued while
// a frame is in flight; further requests are dropped.
// Optional feature: define RENDER_DROP_CNT_EN to count dropped requests.
module frame_render_ctrl #(
  parameter int FB_WIDTH  = 128,
  parameter int FB_HEIGHT = 96
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_render_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam logic [9:0]  LP_X_MAX = 10'(FB_WIDTH - 1);
  localparam logic [9:0]  LP_Y_MAX = 10'(FB_HEIGHT - 1);
  localparam logic [13:0] LP_W14   = 14'(FB_WIDTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_pending;
  logic        w_pending_nxt;
  logic        r_wr_en;
  logic [13:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_frame_done;
  logic        w_last_px;
  logic        w_scan;
  logic [13:0] w_addr;

  assign w_scan    = (r_state == ST_SCAN);
  assign w_last_px = (r_x == LP_X_MAX) && (r_y == LP_Y_MAX);
  assign w_addr    = 14'(r_x) + LP_W14 * 14'(r_y);

  // State register.
  // NOTE: reset is asynchronous so the controller is parked in IDLE with all
  // strobes low the instant reset rises, even mid-frame with no clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a frame in flight is never restarted by frame_start.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.frame_start || r_pending) w_state_nxt = ST_SNAP;
      ST_SNAP: w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last_px) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One-deep request queue: SNAP consumes it, but a request arriving in that
  // same cycle re-arms it. Requests while already pending are dropped.
  always_comb begin
    w_pending_nxt = r_pending;
    unique case (r_state)
      ST_IDLE: w_pending_nxt = r_pending;
      ST_SNAP: w_pending_nxt = bus.frame_start;
      default: if (bus.frame_start) w_pending_nxt = 1'b1;
    endcase
  end

  // Pending flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= 1'b0;
    else       r_pending <= w_pending_nxt;
  end

  // Pixel scan counters: row-major walk during SCAN, held at origin otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_scan && !w_last_px) begin
      if (r_x == LP_X_MAX) begin
        r_x <= '0;
        r_y <= r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end else begin
      r_x <= '0;
      r_y <= '0;
    end
  end

  // One-stage write pipeline: the pixel presented this cycle is written next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= w_scan;
      r_frame_done <= w_scan && w_last_px;
      if (w_scan) begin
        r_wr_addr <= w_addr;
        r_wr_data <= bus.pix_data;
      end
    end
  end

`ifdef RENDER_DROP_CNT_EN
  logic       w_drop;
  logic [7:0] r_drop_cnt;

  // A request is lost when one is already queued, except in SNAP where the
  // queue is being emptied in the same cycle.
  assign w_drop = bus.frame_start && r_pending && (r_state != ST_SNAP);

  // Saturating dropped-request counter, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.snap_en    = (r_state == ST_SNAP);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.frame_done = r_frame_done;

endmodule
